// File: rtl/byte_reg_bank_if.sv
// Memory-mapped slave bus for byte_reg_bank: address/strobes/data in,
// registered read data and its valid strobe out.
interface byte_reg_bank_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
);
  logic [ADDR_WIDTH-1:0]   address;
  logic                    write;
  logic                    read;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic [1:0]              mode;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;

  modport master (
    output address, write, read, writedata, byteenable, mode,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, write, read, writedata, byteenable, mode,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/byte_reg_bank.sv
// Bank of byte-writable registers with overwrite/set/clear/toggle write modes,
// one-cycle registered reads and sticky per-register "changed" flags.
module byte_reg_bank #(
  parameter int                   DATA_WIDTH  = 32,
  parameter int                   NUM_REGS    = 8,
  parameter int                   ADDR_WIDTH  = 3,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           clock,
  input  logic                           reset,
  byte_reg_bank_if.slave                 bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] q,
  output logic [NUM_REGS-1:0]            changed
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] regs      [NUM_REGS];
  logic [DATA_WIDTH-1:0] next_regs [NUM_REGS];
  logic [NUM_REGS-1:0]   write_hit;
  logic [NUM_REGS-1:0]   read_hit;
  logic [NUM_REGS-1:0]   will_change;
  logic [NUM_REGS-1:0]   changed_flags;
  logic [DATA_WIDTH-1:0] read_mux;
  logic [DATA_WIDTH-1:0] readdata_q;
  logic                  readdatavalid_q;

  function automatic logic [7:0] apply_mode(input logic [1:0] m,
                                            input logic [7:0] r,
                                            input logic [7:0] d);
    case (m)
      2'b00:   apply_mode = d;
      2'b01:   apply_mode = r | d;
      2'b10:   apply_mode = r & ~d;
      default: apply_mode = r ^ d;
    endcase
  endfunction

  // Out-of-range addresses match no register, so they neither write nor
  // touch any flag, and their reads fall through to a zero result.
  always_comb begin
    write_hit   = '0;
    read_hit    = '0;
    will_change = '0;
    read_mux    = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      next_regs[k] = regs[k];
      if (bus.address == ADDR_WIDTH'(k)) begin
        write_hit[k] = bus.write;
        read_hit[k]  = bus.read;
        if (bus.read)
          read_mux = regs[k];
      end
      if (write_hit[k]) begin
        for (int b = 0; b < NUM_BYTES; b++) begin
          if (bus.byteenable[b])
            next_regs[k][8*b +: 8] = apply_mode(bus.mode, regs[k][8*b +: 8],
                                                bus.writedata[8*b +: 8]);
        end
      end
      will_change[k] = (next_regs[k] != regs[k]);
    end
  end

  // A write that modifies a register re-sets its flag even when the same
  // register is read (and thus cleared) in that cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_REGS; k++)
        regs[k] <= RESET_VALUE;
      changed_flags   <= '0;
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++)
        regs[k] <= next_regs[k];
      changed_flags   <= (changed_flags & ~read_hit) | will_change;
      readdatavalid_q <= bus.read;
      if (bus.read)
        readdata_q <= read_mux;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_pack
    assign q[k*DATA_WIDTH +: DATA_WIDTH] = regs[k];
  end

  assign changed           = changed_flags;
  assign bus.readdata      = readdata_q;
  assign bus.readdatavalid = readdatavalid_q;

endmodule

// File: tb/tb_byte_reg_bank.sv
// Bench for byte_reg_bank: an 8-register and a 5-register instance share one
// stimulus stream and are compared against a word-level reference model.
module tb_byte_reg_bank;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wr, rd;
  logic [2:0]  addr;
  logic [31:0] wd;
  logic [3:0]  be;
  logic [1:0]  md;

  logic [255:0] q8;
  logic [159:0] q5;
  logic [7:0]   changed8;
  logic [4:0]   changed5;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  byte_reg_bank_if #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) bus8 ();
  byte_reg_bank_if #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) bus5 ();

  assign bus8.write = wr;  assign bus8.read = rd;  assign bus8.address = addr;
  assign bus8.writedata = wd;  assign bus8.byteenable = be;  assign bus8.mode = md;
  assign bus5.write = wr;  assign bus5.read = rd;  assign bus5.address = addr;
  assign bus5.writedata = wd;  assign bus5.byteenable = be;  assign bus5.mode = md;

  byte_reg_bank #(.DATA_WIDTH(32), .NUM_REGS(8), .ADDR_WIDTH(3), .RESET_VALUE(32'h0)) dut8 (
    .clock(clock), .reset(reset), .bus(bus8.slave), .q(q8), .changed(changed8));

  byte_reg_bank #(.DATA_WIDTH(32), .NUM_REGS(5), .ADDR_WIDTH(3), .RESET_VALUE(32'h0)) dut5 (
    .clock(clock), .reset(reset), .bus(bus5.slave), .q(q5), .changed(changed5));

  // Reference state: index 0 models the 8-register bank, index 1 the 5-register bank.
  logic [31:0] m_regs [2][8];
  logic [7:0]  m_chg  [2];
  logic [31:0] m_rd   [2];
  logic        m_rdv  [2];
  int          n_regs [2] = '{8, 5};

  typedef struct {
    logic        w;
    logic        r;
    logic [2:0]  a;
    logic [31:0] d;
    logic [3:0]  b;
    logic [1:0]  m;
    logic [2:0]  chk;
    logic [31:0] exp_reg;
    logic        exp_rdv;
    logic [31:0] exp_rd;
    logic [7:0]  exp_chg;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] byte_mask(input logic [3:0] b);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++)
      if (b[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 8; k++) m_regs[d][k] = '0;
      m_chg[d] = '0;
      m_rd[d]  = '0;
      m_rdv[d] = 1'b0;
    end
  endtask

  task automatic model_step();
    logic [31:0] mask, dm, old, nv;
    mask = byte_mask(be);
    dm   = wd & mask;
    for (int d = 0; d < 2; d++) begin
      m_rdv[d] = rd;
      if (rd) begin
        m_rd[d] = (int'(addr) < n_regs[d]) ? m_regs[d][addr] : 32'h0;
        if (int'(addr) < n_regs[d]) m_chg[d][addr] = 1'b0;
      end
      if (wr && int'(addr) < n_regs[d]) begin
        old = m_regs[d][addr];
        case (md)
          2'b00:   nv = (old & ~mask) | dm;
          2'b01:   nv = old | dm;
          2'b10:   nv = old & ~dm;
          default: nv = old ^ dm;
        endcase
        if (nv != old) m_chg[d][addr] = 1'b1;
        m_regs[d][addr] = nv;
      end
    end
  endtask

  task automatic check_output(input string tag);
    logic [255:0] exp_q;
    for (int d = 0; d < 2; d++) begin
      exp_q = '0;
      for (int k = 0; k < n_regs[d]; k++) exp_q[k*32 +: 32] = m_regs[d][k];
      if (d == 0) begin
        check({tag, "_q8"}, q8, exp_q);
        check({tag, "_changed8"}, 256'(changed8), 256'(m_chg[0]));
        check({tag, "_rdv8"}, 256'(bus8.readdatavalid), 256'(m_rdv[0]));
        check({tag, "_rd8"}, 256'(bus8.readdata), 256'(m_rd[0]));
      end else begin
        check({tag, "_q5"}, 256'(q5), exp_q);
        check({tag, "_changed5"}, 256'(changed5), 256'(m_chg[1][4:0]));
        check({tag, "_rdv5"}, 256'(bus5.readdatavalid), 256'(m_rdv[1]));
        check({tag, "_rd5"}, 256'(bus5.readdata), 256'(m_rd[1]));
      end
    end
  endtask

  task automatic apply_stimulus(input logic w, input logic r, input logic [2:0] a,
                                input logic [31:0] d, input logic [3:0] b,
                                input logic [1:0] m, input string tag);
    wr = w; rd = r; addr = a; wd = d; be = b; md = m;
    @(posedge clock);
    model_step();
    #1;
    check_output(tag);
    wr = 1'b0; rd = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_reads [3];
    logic [2:0]  read_addrs [3];

    vecs[0]  = '{1'b1, 1'b0, 3'd2, 32'hAABBCCDD, 4'b0101, 2'b00, 3'd2, 32'h00BB00DD, 1'b0, 32'h0,        8'h04};
    vecs[1]  = '{1'b0, 1'b1, 3'd2, 32'h0,        4'b0000, 2'b00, 3'd2, 32'h00BB00DD, 1'b1, 32'h00BB00DD, 8'h00};
    vecs[2]  = '{1'b1, 1'b0, 3'd0, 32'h000000F0, 4'b1111, 2'b00, 3'd0, 32'h000000F0, 1'b0, 32'h00BB00DD, 8'h01};
    vecs[3]  = '{1'b1, 1'b0, 3'd0, 32'h0000000F, 4'b1111, 2'b01, 3'd0, 32'h000000FF, 1'b0, 32'h00BB00DD, 8'h01};
    vecs[4]  = '{1'b1, 1'b0, 3'd0, 32'h000000F0, 4'b1111, 2'b10, 3'd0, 32'h0000000F, 1'b0, 32'h00BB00DD, 8'h01};
    vecs[5]  = '{1'b1, 1'b0, 3'd0, 32'hFFFFFFFF, 4'b1111, 2'b11, 3'd0, 32'hFFFFFFF0, 1'b0, 32'h00BB00DD, 8'h01};
    vecs[6]  = '{1'b0, 1'b1, 3'd0, 32'h0,        4'b0000, 2'b00, 3'd0, 32'hFFFFFFF0, 1'b1, 32'hFFFFFFF0, 8'h00};
    vecs[7]  = '{1'b1, 1'b0, 3'd1, 32'h00000005, 4'b1111, 2'b00, 3'd1, 32'h00000005, 1'b0, 32'hFFFFFFF0, 8'h02};
    vecs[8]  = '{1'b0, 1'b1, 3'd1, 32'h0,        4'b0000, 2'b00, 3'd1, 32'h00000005, 1'b1, 32'h00000005, 8'h00};
    vecs[9]  = '{1'b1, 1'b0, 3'd1, 32'h00000001, 4'b1111, 2'b01, 3'd1, 32'h00000005, 1'b0, 32'h00000005, 8'h00};
    vecs[10] = '{1'b1, 1'b0, 3'd3, 32'h00000011, 4'b1111, 2'b00, 3'd3, 32'h00000011, 1'b0, 32'h00000005, 8'h08};
    vecs[11] = '{1'b0, 1'b1, 3'd3, 32'h0,        4'b0000, 2'b00, 3'd3, 32'h00000011, 1'b1, 32'h00000011, 8'h00};
    vecs[12] = '{1'b1, 1'b1, 3'd3, 32'h00000022, 4'b1111, 2'b00, 3'd3, 32'h00000022, 1'b1, 32'h00000011, 8'h08};
    vecs[13] = '{1'b0, 1'b1, 3'd3, 32'h0,        4'b0000, 2'b00, 3'd3, 32'h00000022, 1'b1, 32'h00000022, 8'h00};

    wr = 1'b0; rd = 1'b0; addr = '0; wd = '0; be = '0; md = '0;
    model_reset();
    #12;
    check_output("reset");
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      apply_stimulus(vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].d, vecs[i].b, vecs[i].m,
                     $sformatf("vec%0d", i));
      check($sformatf("vec%0d_reg", i), 256'(q8[32*vecs[i].chk +: 32]), 256'(vecs[i].exp_reg));
      check($sformatf("vec%0d_rdv", i), 256'(bus8.readdatavalid), 256'(vecs[i].exp_rdv));
      check($sformatf("vec%0d_rd", i), 256'(bus8.readdata), 256'(vecs[i].exp_rd));
      check($sformatf("vec%0d_chg", i), 256'(changed8), 256'(vecs[i].exp_chg));
    end

    // Address 6 exists in the 8-register bank but not in the 5-register one.
    apply_stimulus(1'b1, 1'b0, 3'd6, 32'hDEADBEEF, 4'b1111, 2'b00, "oor_write");
    check("oor_write_q5", 256'(q5),
          256'({32'h0, 32'h22, 32'h00BB00DD, 32'h5, 32'hFFFFFFF0}));
    check("oor_write_chg5", 256'(changed5), 256'(5'h00));
    check("oor_write_chg8", 256'(changed8), 256'(8'h40));

    apply_stimulus(1'b0, 1'b1, 3'd7, 32'h0, 4'b0000, 2'b00, "oor_read");
    check("oor_read_rd5", 256'(bus5.readdata), 256'(32'h0));
    check("oor_read_rdv5", 256'(bus5.readdatavalid), 256'(1'b1));

    read_addrs = '{3'd1, 3'd3, 3'd7};
    exp_reads  = '{32'h5, 32'h22, 32'h0};
    wr = 1'b0; be = '0; md = '0; wd = '0;
    rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr = read_addrs[i];
      @(posedge clock);
      model_step();
      #1;
      check_output($sformatf("b2b%0d", i));
      check($sformatf("b2b%0d_rdv5", i), 256'(bus5.readdatavalid), 256'(1'b1));
      check($sformatf("b2b%0d_rd5", i), 256'(bus5.readdata), 256'(exp_reads[i]));
    end
    rd = 1'b0;

    // Reset lands while a read is pending: outputs must clear without a clock edge.
    apply_stimulus(1'b1, 1'b0, 3'd4, 32'h12345678, 4'b1111, 2'b00, "pre_reset");
    wr = 1'b0; rd = 1'b1; addr = 3'd4;
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_output("mid_reset");
    check("mid_reset_q8", q8, 256'h0);
    check("mid_reset_rdv8", 256'(bus8.readdatavalid), 256'(1'b0));
    check("mid_reset_chg8", 256'(changed8), 256'(8'h00));
    @(posedge clock);
    #1;
    check("held_reset_rdv8", 256'(bus8.readdatavalid), 256'(1'b0));
    check_output("held_reset");
    rd = 1'b0;
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 400; i++) begin
      apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     3'($urandom_range(0, 7)), $urandom,
                     4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                     $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
